// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the scanned 7-segment receive path.
// Segment codes are active-low with bit 7 = dp and bits [6:0] = g..a.
package fnd_pkg;

   // Digit fonts with the decimal point off
   localparam logic [7:0] SEG_0       = 8'hc0;
   localparam logic [7:0] SEG_1       = 8'hf9;
   localparam logic [7:0] SEG_2       = 8'ha4;
   localparam logic [7:0] SEG_3       = 8'hb0;
   localparam logic [7:0] SEG_4       = 8'h99;
   localparam logic [7:0] SEG_5       = 8'h92;
   localparam logic [7:0] SEG_6       = 8'h82;
   localparam logic [7:0] SEG_7       = 8'hf8;
   localparam logic [7:0] SEG_8       = 8'h80;
   localparam logic [7:0] SEG_9       = 8'h90;
   localparam logic [7:0] SEG_DP_ONLY = 8'h7f;
   localparam logic [7:0] SEG_BLANK   = 8'hff;

   localparam logic [3:0] CODE_BLANK  = 4'ha;
   localparam logic [3:0] CODE_ERR    = 4'he;

   localparam logic [3:0] COMM_IDLE   = 4'hf;

   // Number of driven (low) digit commons; one-hot means exactly one
   function automatic logic [2:0] comm_low_count(input logic [3:0] comm);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (!comm[i]) begin
            n = n + 3'd1;
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/fnd_scan_decoder_seg_to_bcd.sv
// Segment pattern to digit code. The single inverse of the font table:
// anything that is not a known digit or blank reports illegal.
module seg_to_bcd
   import fnd_pkg::*;
(
   input  logic [6:0] font,
   output logic [3:0] code,
   output logic       illegal
);

   // Pattern match against the font table; dp is handled by the caller
   always_comb begin
      code    = CODE_ERR;
      illegal = 1'b0;
      case (font)
         SEG_0[6:0]:     code = 4'd0;
         SEG_1[6:0]:     code = 4'd1;
         SEG_2[6:0]:     code = 4'd2;
         SEG_3[6:0]:     code = 4'd3;
         SEG_4[6:0]:     code = 4'd4;
         SEG_5[6:0]:     code = 4'd5;
         SEG_6[6:0]:     code = 4'd6;
         SEG_7[6:0]:     code = 4'd7;
         SEG_8[6:0]:     code = 4'd8;
         SEG_9[6:0]:     code = 4'd9;
         SEG_BLANK[6:0]: code = CODE_BLANK;
         default: begin
            code    = CODE_ERR;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Receive side of a 4-digit multiplexed 7-segment bus. Synchronizes the
// scanned font/common lines, waits for a dwell to be stable long enough,
// then decodes it into the addressed slot as registered BCD.
module fnd_scan_decoder
   import fnd_pkg::*;
#(
   parameter int STABLE_CYCLES = 16
)
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] fnd_font,
   input  logic [3:0] fnd_comm,
   output logic [3:0] digit_0,
   output logic [3:0] digit_1,
   output logic [3:0] digit_2,
   output logic [3:0] digit_3,
   output logic [3:0] dp,
   output logic [3:0] digit_valid,
   output logic       digit_strobe,
   output logic       frame_done,
   output logic       err
);

   localparam int              CNT_W   = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [11:0]     IDLE_BUS = {COMM_IDLE, SEG_BLANK};

   logic [11:0]      meta_r;
   logic [11:0]      sync_r;
   logic [11:0]      hold_r;
   logic [CNT_W-1:0] cnt_r;
   logic             done_r;

   logic [3:0]       digit_r [4];
   logic [3:0]       dp_r;
   logic [3:0]       valid_r;
   logic [3:0]       seen_r;
   logic             strobe_r;
   logic             frame_r;
   logic             err_r;

   logic             change_s;
   logic             accept_s;
   logic [3:0]       comm_s;
   logic             idle_s;
   logic             onehot_s;
   logic [1:0]       slot_s;
   logic [3:0]       slot_mask_s;
   logic [3:0]       seen_next_s;
   logic [3:0]       code_s;
   logic             illegal_s;

   // Two-flop synchronizer; resets to the idle bus so release is quiet
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_r <= IDLE_BUS;
         sync_r <= IDLE_BUS;
      end else begin
         meta_r <= {fnd_comm, fnd_font};
         sync_r <= meta_r;
      end
   end

   // A dwell is accepted only while the synchronized bus still matches it,
   // so a value must survive one sample past the counter reaching its end
   assign change_s = (sync_r != hold_r);
   assign accept_s = !change_s && (cnt_r == CNT_MAX) && !done_r;

   // Stability tracker: restart on any change, fire once per dwell
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_r <= IDLE_BUS;
         cnt_r  <= '0;
         done_r <= 1'b0;
      end else if (change_s) begin
         hold_r <= sync_r;
         cnt_r  <= '0;
         done_r <= 1'b0;
      end else begin
         if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
         if (accept_s) begin
            done_r <= 1'b1;
         end
      end
   end

   seg_to_bcd u_seg_to_bcd (
      .font    (hold_r[6:0]),
      .code    (code_s),
      .illegal (illegal_s)
   );

   assign comm_s      = hold_r[11:8];
   assign idle_s      = (comm_s == COMM_IDLE);
   assign onehot_s    = (comm_low_count(comm_s) == 3'd1);
   assign slot_mask_s = ~comm_s;
   assign seen_next_s = seen_r | slot_mask_s;

   // Slot index of a one-hot-low common; unused for other patterns
   always_comb begin
      slot_s = 2'd0;
      case (comm_s)
         4'b1110: slot_s = 2'd0;
         4'b1101: slot_s = 2'd1;
         4'b1011: slot_s = 2'd2;
         4'b0111: slot_s = 2'd3;
         default: slot_s = 2'd0;
      endcase
   end

   // Slot registers, frame tracking and single-cycle event pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            digit_r[i] <= CODE_BLANK;
         end
         dp_r     <= 4'h0;
         valid_r  <= 4'h0;
         seen_r   <= 4'h0;
         strobe_r <= 1'b0;
         frame_r  <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         strobe_r <= 1'b0;
         frame_r  <= 1'b0;
         err_r    <= 1'b0;
         if (accept_s) begin
            if (onehot_s) begin
               digit_r[slot_s] <= code_s;
               dp_r[slot_s]    <= ~hold_r[7];
               valid_r         <= valid_r | slot_mask_s;
               strobe_r        <= 1'b1;
               err_r           <= illegal_s;
               if (seen_next_s == 4'hf) begin
                  frame_r <= 1'b1;
                  seen_r  <= 4'h0;
               end else begin
                  seen_r  <= seen_next_s;
               end
            end else if (!idle_s) begin
               err_r <= 1'b1;
            end
         end
      end
   end

   assign digit_0      = digit_r[0];
   assign digit_1      = digit_r[1];
   assign digit_2      = digit_r[2];
   assign digit_3      = digit_r[3];
   assign dp           = dp_r;
   assign digit_valid  = valid_r;
   assign digit_strobe = strobe_r;
   assign frame_done   = frame_r;
   assign err          = err_r;

endmodule
